// File: rtl/oldest2_issue_queue_if.sv
// Handshake bundle between the issue queue and its neighbours (enqueue, wakeup,
// arbiter request/grant, issue ports). The queue takes the slave modport.
interface oldest2_issue_queue_if #(
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
);
    logic                  flush_i;
    logic                  enq_valid_i;
    logic                  enq_ready_o;
    logic [DATA_WIDTH-1:0] enq_data_i;
    logic                  enq_src_rdy_i;
    logic [TAG_WIDTH-1:0]  enq_src_tag_i;
    logic                  wake_valid_i;
    logic [TAG_WIDTH-1:0]  wake_tag_i;
    logic [DEPTH-1:0]      arb_req_o;
    logic [PTR_WIDTH-1:0]  arb_head_o;
    logic                  grant_first_valid_i;
    logic [PTR_WIDTH-1:0]  grant_first_index_i;
    logic                  grant_second_valid_i;
    logic [PTR_WIDTH-1:0]  grant_second_index_i;
    logic                  issue_ready_i;
    logic                  issue0_valid_o;
    logic [DATA_WIDTH-1:0] issue0_data_o;
    logic                  issue1_valid_o;
    logic [DATA_WIDTH-1:0] issue1_data_o;
    logic [PTR_WIDTH:0]    count_o;

    modport slave (
        input  flush_i, enq_valid_i, enq_data_i, enq_src_rdy_i, enq_src_tag_i,
               wake_valid_i, wake_tag_i, grant_first_valid_i, grant_first_index_i,
               grant_second_valid_i, grant_second_index_i, issue_ready_i,
        output enq_ready_o, arb_req_o, arb_head_o, issue0_valid_o, issue0_data_o,
               issue1_valid_o, issue1_data_o, count_o
    );

    modport master (
        output flush_i, enq_valid_i, enq_data_i, enq_src_rdy_i, enq_src_tag_i,
               wake_valid_i, wake_tag_i, grant_first_valid_i, grant_first_index_i,
               grant_second_valid_i, grant_second_index_i, issue_ready_i,
        input  enq_ready_o, arb_req_o, arb_head_o, issue0_valid_o, issue0_data_o,
               issue1_valid_o, issue1_data_o, count_o
    );
endinterface

// File: rtl/oldest2_issue_queue.sv
// Circular in-order-allocated 2-issue queue feeding the oldest-2 arbiter; entries
// wake on tag broadcast, issue out of order, and the head skips issued holes.
module oldest2_issue_queue #(
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    oldest2_issue_queue_if.slave  io
);
    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [DEPTH-1:0]                 rdy_q, rdy_d;
    logic [DEPTH-1:0][TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [PTR_WIDTH:0]               head_q, head_d;
    logic [PTR_WIDTH:0]               tail_q, tail_d;

    logic [PTR_WIDTH:0]   count;
    logic                 enq_fire, fire0, fire1;
    logic [DEPTH-1:0]     arb_req, valid_post;
    logic [PTR_WIDTH:0]   head_step;
    logic [PTR_WIDTH-1:0] tail_slot;

    always_comb begin
        count     = tail_q - head_q;
        arb_req   = valid_q & rdy_q;
        tail_slot = tail_q[PTR_WIDTH-1:0];

        io.count_o        = count;
        io.enq_ready_o    = (count != (PTR_WIDTH+1)'(DEPTH));
        io.arb_req_o      = arb_req;
        io.arb_head_o     = head_q[PTR_WIDTH-1:0];
        io.issue0_valid_o = io.grant_first_valid_i & arb_req[io.grant_first_index_i];
        io.issue0_data_o  = data_q[io.grant_first_index_i];
        io.issue1_valid_o = io.grant_second_valid_i & arb_req[io.grant_second_index_i];
        io.issue1_data_o  = data_q[io.grant_second_index_i];

        fire0    = io.issue0_valid_o & io.issue_ready_i;
        fire1    = io.issue1_valid_o & io.issue_ready_i;
        enq_fire = io.enq_valid_i & io.enq_ready_o & ~io.flush_i;

        valid_d = valid_q;
        rdy_d   = rdy_q;
        tag_d   = tag_q;
        data_d  = data_q;
        tail_d  = tail_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (io.wake_valid_i && valid_q[i] && !rdy_q[i] && tag_q[i] == io.wake_tag_i)
                rdy_d[i] = 1'b1;
        end

        // Dequeue after wakeup so an entry woken and issued together ends up cleared.
        if (fire0) begin
            valid_d[io.grant_first_index_i] = 1'b0;
            rdy_d[io.grant_first_index_i]   = 1'b0;
        end
        if (fire1) begin
            valid_d[io.grant_second_index_i] = 1'b0;
            rdy_d[io.grant_second_index_i]   = 1'b0;
        end
        valid_post = valid_d;

        if (enq_fire) begin
            valid_d[tail_slot] = 1'b1;
            rdy_d[tail_slot]   = io.enq_src_rdy_i |
                                 (io.wake_valid_i & (io.wake_tag_i == io.enq_src_tag_i));
            tag_d[tail_slot]   = io.enq_src_tag_i;
            data_d[tail_slot]  = io.enq_data_i;
            tail_d             = tail_q + 1'b1;
        end

        // Comparing against the pre-enqueue tail keeps the head off a freshly written slot.
        head_step = head_q;
        if (!valid_post[head_q[PTR_WIDTH-1:0]] && head_q != tail_q) begin
            head_step = head_q + 1'b1;
            if (!valid_post[head_step[PTR_WIDTH-1:0]] && head_step != tail_q)
                head_step = head_step + 1'b1;
        end
        head_d = head_step;

        if (io.flush_i) begin
            valid_d = '0;
            rdy_d   = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            rdy_q   <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end
endmodule

// File: tb/tb_oldest2_issue_queue.sv
// Directed bench for oldest2_issue_queue: expected issue payloads go into a
// scoreboard queue when grants are driven and are popped as the ports fire.
module tb_oldest2_issue_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oldest2_issue_queue_if #(.DEPTH(8), .PTR_WIDTH(3), .DATA_WIDTH(32), .TAG_WIDTH(6)) io ();

    oldest2_issue_queue #(.DEPTH(8), .PTR_WIDTH(3), .DATA_WIDTH(32), .TAG_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    int n_run  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] slot_data [8];
    int tb_tail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        io.flush_i = 0; io.enq_valid_i = 0; io.enq_data_i = '0;
        io.enq_src_rdy_i = 0; io.enq_src_tag_i = '0;
        io.wake_valid_i = 0; io.wake_tag_i = '0;
        io.grant_first_valid_i = 0; io.grant_first_index_i = '0;
        io.grant_second_valid_i = 0; io.grant_second_index_i = '0;
        io.issue_ready_i = 0;
    endtask

    // Enqueue one uop expected to be accepted; remembers its payload per slot.
    task automatic enq(input logic [31:0] d, input bit rdy, input logic [5:0] tag);
        io.enq_valid_i = 1; io.enq_data_i = d; io.enq_src_rdy_i = rdy; io.enq_src_tag_i = tag;
        slot_data[tb_tail % 8] = d;
        tb_tail++;
        tick();
        io.enq_valid_i = 0; io.enq_src_rdy_i = 0;
    endtask

    task automatic issue(input bit v0, input int i0, input bit v1, input int i1);
        io.grant_first_valid_i = v0;  io.grant_first_index_i  = 3'(i0);
        io.grant_second_valid_i = v1; io.grant_second_index_i = 3'(i1);
        io.issue_ready_i = 1;
        if (v0) exp_q.push_back(slot_data[i0]);
        if (v1) exp_q.push_back(slot_data[i1]);
        #1;
        chk("iss0_valid", io.issue0_valid_o, v0);
        chk("iss1_valid", io.issue1_valid_o, v1);
        if (io.issue0_valid_o && exp_q.size() > 0) chk("iss0_data", io.issue0_data_o, exp_q.pop_front());
        if (io.issue1_valid_o && exp_q.size() > 0) chk("iss1_data", io.issue1_data_o, exp_q.pop_front());
        tick();
        idle();
    endtask

    task automatic do_flush(input bit with_enq);
        io.flush_i = 1;
        io.enq_valid_i = with_enq; io.enq_data_i = 32'hDEAD_BEEF; io.enq_src_rdy_i = 1;
        tick();
        idle();
        tb_tail = 0;
    endtask

    initial begin
        idle();
        #12;
        chk("rst_count", io.count_o, 0);
        chk("rst_req", io.arb_req_o, 0);
        chk("rst_head", io.arb_head_o, 0);
        chk("rst_enq_ready", io.enq_ready_o, 1);
        chk("rst_iss0", io.issue0_valid_o, 0);
        @(negedge clk);
        rst = 0;
        tick();

        // Basic dual issue from the head.
        for (int i = 0; i < 3; i++) enq(32'hA000_0000 + 32'(i), 1, 6'd0);
        chk("t1_req", io.arb_req_o, 8'b0000_0111);
        chk("t1_count", io.count_o, 3);
        chk("t1_head", io.arb_head_o, 0);
        issue(1, 0, 1, 1);
        chk("t1_req_after", io.arb_req_o, 8'b0000_0100);
        chk("t1_head_after", io.arb_head_o, 2);
        chk("t1_count_after", io.count_o, 1);
        do_flush(0);

        // Full queue; a 9th enqueue must not overwrite slot 0.
        for (int i = 0; i < 8; i++) enq(32'hB000_0000 + 32'(i), 1, 6'd0);
        chk("t2_full_ready", io.enq_ready_o, 0);
        chk("t2_full_count", io.count_o, 8);
        io.enq_valid_i = 1; io.enq_data_i = 32'hBAD0_0009; io.enq_src_rdy_i = 1;
        tick();
        idle();
        chk("t2_ninth_count", io.count_o, 8);
        issue(1, 0, 0, 0);
        chk("t2_ready_again", io.enq_ready_o, 1);
        chk("t2_count_after", io.count_o, 7);
        do_flush(0);

        // Wakeup of a hole blocking the head.
        enq(32'hC000_0000, 0, 6'd5);
        enq(32'hC000_0001, 1, 6'd0);
        chk("t3_req", io.arb_req_o, 8'b0000_0010);
        issue(1, 1, 0, 0);
        chk("t3_head_stuck", io.arb_head_o, 0);
        chk("t3_count_stuck", io.count_o, 2);
        io.wake_valid_i = 1; io.wake_tag_i = 6'd4;
        tick();
        idle();
        chk("t3_wrong_tag", io.arb_req_o, 8'b0000_0000);
        io.wake_valid_i = 1; io.wake_tag_i = 6'd5;
        tick();
        idle();
        chk("t3_woken", io.arb_req_o, 8'b0000_0001);
        issue(1, 0, 0, 0);
        chk("t3_head_jump", io.arb_head_o, 2);
        chk("t3_count_zero", io.count_o, 0);

        // Enqueue and matching wakeup in the same cycle.
        io.wake_valid_i = 1; io.wake_tag_i = 6'd9;
        enq(32'hD000_0002, 0, 6'd9);
        idle();
        chk("t4_same_cycle_wake", io.arb_req_o, 8'b0000_0100);
        issue(1, 2, 0, 0);
        do_flush(0);

        // Wrap-around of head and tail.
        for (int i = 0; i < 6; i++) enq(32'hE000_0000 + 32'(i), 1, 6'd0);
        issue(1, 0, 1, 1);
        issue(1, 2, 1, 3);
        issue(1, 4, 1, 5);
        chk("t5_head6", io.arb_head_o, 6);
        chk("t5_empty", io.count_o, 0);
        for (int i = 0; i < 4; i++) enq(32'hE100_0000 + 32'(i), 1, 6'd0);
        chk("t5_head_pre", io.arb_head_o, 6);
        chk("t5_req_wrap", io.arb_req_o, 8'b1100_0011);
        chk("t5_count4", io.count_o, 4);
        issue(1, 6, 1, 7);
        chk("t5_head_wrap", io.arb_head_o, 0);
        chk("t5_count2", io.count_o, 2);

        // Flush with a concurrent enqueue.
        for (int i = 0; i < 3; i++) enq(32'hF000_0000 + 32'(i), 1, 6'd0);
        chk("t6_count5", io.count_o, 5);
        do_flush(1);
        chk("t6_count", io.count_o, 0);
        chk("t6_req", io.arb_req_o, 0);
        chk("t6_ready", io.enq_ready_o, 1);
        chk("t6_head", io.arb_head_o, 0);
        enq(32'hF100_0000, 1, 6'd0);
        chk("t6_tail_zero", io.arb_req_o, 8'b0000_0001);

        // Asynchronous reset mid-operation.
        enq(32'hF100_0001, 1, 6'd0);
        rst = 1;
        #1;
        chk("t7_rst_count", io.count_o, 0);
        chk("t7_rst_req", io.arb_req_o, 0);
        @(negedge clk);
        rst = 0;
        tb_tail = 0;

        chk("sb_empty", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/oldest2_issue_queue.md
Name: oldest2_issue_queue

Overview:
- Circular 2-issue scheduling queue directly upstream of the oldest-2 arbiter in the RCU.
- Holds in-order-allocated uops and tracks source readiness via a tag wakeup broadcast.
- Presents the ready-entry request vector and head pointer to the arbiter.
- Consumes the arbiter's two grant indices to drive two issue ports and free the issued entries.

Parameters:
DEPTH, 8, number of entries; power of two; equals arbiter SEL_WIDTH
PTR_WIDTH, 3, log2(DEPTH); equals arbiter PRIORITY_WIDTH
DATA_WIDTH, 32, uop payload width
TAG_WIDTH, 6, physical-register wakeup tag width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush_i  in  1  clear the whole queue
enq_valid_i  in  1  enqueue request
enq_ready_o  out  1  queue not full
enq_data_i  in  DATA_WIDTH  uop payload
enq_src_rdy_i  in  1  source operand already ready
enq_src_tag_i  in  TAG_WIDTH  tag to wait for when not ready
wake_valid_i  in  1  wakeup broadcast valid
wake_tag_i  in  TAG_WIDTH  wakeup tag
arb_req_o  out  DEPTH  bit i = entry i valid and ready
arb_head_o  out  PTR_WIDTH  oldest slot index (arbiter priority)
grant_first_valid_i  in  1  arbiter first grant valid
grant_first_index_i  in  PTR_WIDTH  first granted entry
grant_second_valid_i  in  1  arbiter second grant valid
grant_second_index_i  in  PTR_WIDTH  second granted entry
issue_ready_i  in  1  downstream accepts both issue ports this cycle
issue0_valid_o  out  1  issue port 0 valid
issue0_data_o  out  DATA_WIDTH  port 0 payload
issue1_valid_o  out  1  issue port 1 valid
issue1_data_o  out  DATA_WIDTH  port 1 payload
count_o  out  PTR_WIDTH+1  occupied slots from head to tail, holes included

Behaviour:
- State:
  - Per entry: valid, rdy, tag, data.
  - head and tail pointers, each PTR_WIDTH+1 bits; MSB is the wrap bit.
  - count = tail - head, computed modulo 2^(PTR_WIDTH+1).
- Reset: all valid=0 and rdy=0; head=tail=0; arb_req_o=0, arb_head_o=0, count_o=0, enq_ready_o=1, issue*_valid_o=0; data/tag are don't-care.
- enq_ready_o = (count != DEPTH), from registered state only; a same-cycle dequeue does not make room.
- Enqueue fires on enq_valid_i & enq_ready_o & !flush_i:
  - writes slot tail[PTR_WIDTH-1:0]: valid=1, data, tag.
  - rdy = enq_src_rdy_i | (wake_valid_i & wake_tag_i==enq_src_tag_i).
  - tail += 1, wrapping naturally.
- Wakeup: every valid entry with rdy=0 and tag==wake_tag_i sets rdy=1 at the next edge; visible in arb_req_o the cycle after the wakeup.
- arb_req_o[i] = valid[i] & rdy[i], registered state, combinational output. arb_head_o = head[PTR_WIDTH-1:0].
- Issue path is combinational, 0 cycles from grant:
  - issue0_valid_o = grant_first_valid_i & arb_req_o[grant_first_index_i]; issue0_data_o = data[grant_first_index_i].
  - Port 1 is identical, using the second grant.
  - Data outputs are don't-care when not valid.
- Dequeue: port N fires on issueN_valid_o & issue_ready_i; the fired entry clears valid and rdy at the edge. Both ports may fire in one cycle.
- Holes are allowed; issued entries need not be at head.
- Head advance, evaluated on post-dequeue valid bits:
  - If slot head is invalid and head != tail, advance 1.
  - If the next slot is also invalid and still != tail, advance 2.
  - Maximum 2 per cycle.
  - Leftover holes drain over subsequent cycles.
- Flush: dominates everything. At the next edge: all valid/rdy=0, head=tail=0; enqueue, dequeue and wakeup that cycle are discarded. Issue outputs are not gated by flush.
- Simultaneous events:
  - Enqueue, wakeup and two dequeues in one cycle are all legal. They touch disjoint slots, because the tail slot is free when not full.
  - A wakeup matching an entry issued the same cycle leaves that entry invalid.
- Reset asserted mid-operation returns to the reset state immediately; no partial state survives.

Test Plan:
- Reset, enqueue 3 uops with rdy=1 on cycles 1-3 -> arb_req_o=8'b0000_0111, count_o=3, arb_head_o=0. Grants 0 and 1 with issue_ready_i=1 -> both issue valid carry payloads of slots 0/1; next cycle arb_req_o=8'b0000_0100, head=2, count_o=1.
- Enqueue 8 uops without issue -> enq_ready_o=0 after 8th, count_o=8. A 9th enq_valid_i is ignored. Issue slot 0 -> enq_ready_o=1 next cycle.
- Enqueue slot 0 waiting on tag 5, slot 1 ready. Grant only index 1 and issue -> head stays 0. wake_tag_i=5 -> arb_req_o[0]=1 a cycle later. Issue it -> head jumps to 2 in one cycle.
- Enqueue not-ready tag 9 in the same cycle as wake_valid_i with tag 9 -> entry has rdy=1 and appears in arb_req_o on the following cycle.
- Wrap: drive head/tail to 6. Enqueue 4 (slots 6,7,0,1) -> arb_head_o=6. Grants 6 and 7 issued -> head=0, wrap bit toggles, count_o=2.
- Queue holding 5 entries, flush_i with enq_valid_i=1 -> next cycle count_o=0, arb_req_o=0, enq_ready_o=1, head=tail=0.
